// File: rtl/rv_pkg.sv
// Shared RV32I core types and constants.
package rv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_FLUSH
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/rv_fetch_fifo.sv
// Small synchronous FIFO with flush. The instruction buffer and the
// in-flight PC queue both use it. DEPTH must be a power of two >= 2.
module rv_fetch_fifo
  import rv_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type T       = fetch_entry_t,
  parameter T    RST_VAL = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  T                       wdata,
  input  logic                   pop,
  input  logic                   flush,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output T                       head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  // A pop in the same cycle frees the slot, so push-on-full is fine then.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  // Storage, pointers and occupancy; flush empties without touching data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= RST_VAL;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rv_fetch_unit.sv
// Instruction fetch front-end: owns the PC, issues word-aligned imem
// requests, buffers responses in order and hands them to decode.
module rv_fetch_unit
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  fetch_state_t    state, state_nxt;
  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   outstanding, discard, redir_discard;
  logic [CW-1:0]   fifo_count, pcq_count;
  logic [CW:0]     inflight_sum;
  logic            fifo_full, fifo_empty, pcq_full, pcq_empty;
  logic            req_fire, rsp_keep, rsp_drop, if_pop;
  fetch_entry_t    fifo_head, rsp_entry;
  logic [XLEN-1:0] pcq_head;

  // Issue only while every possible response is guaranteed a buffer slot.
  assign inflight_sum   = {1'b0, outstanding} + {1'b0, fifo_count};
  assign imem_req_valid = (state == S_RUN) && (inflight_sum < {1'b0, DEPTH_C});
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_drop  = imem_rsp_valid && (discard != '0);
  assign rsp_keep  = imem_rsp_valid && (discard == '0) && !pcq_empty;
  assign rsp_entry = '{pc: pcq_head, instr: imem_rsp_data};
  assign if_pop    = !fifo_empty && if_ready;

  // Everything still in flight after a redirect edge becomes stale.
  assign redir_discard = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);

  assign if_valid = !fifo_empty;
  assign if_pc    = fifo_head.pc;
  assign if_instr = fifo_head.instr;

  rv_fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .T       (fetch_entry_t),
    .RST_VAL ({{XLEN{1'b0}}, NOP_INSTR})
  ) u_ifq (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rsp_keep),
    .wdata (rsp_entry),
    .pop   (if_pop),
    .flush (redirect_valid),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (fifo_head)
  );

  rv_fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .T       (logic [XLEN-1:0]),
    .RST_VAL ('0)
  ) u_pcq (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (req_fire),
    .wdata (fetch_pc),
    .pop   (rsp_keep),
    .flush (redirect_valid),
    .full  (pcq_full),
    .empty (pcq_empty),
    .count (pcq_count),
    .head  (pcq_head)
  );

  // Next state; the FLUSH exit looks ahead so the new PC issues right
  // after the last dropped response.
  always_comb begin
    state_nxt = state;
    case (state)
      S_BOOT:  state_nxt = S_RUN;
      S_RUN:   state_nxt = S_RUN;
      S_FLUSH: if (discard == '0 || (discard == CW'(1) && imem_rsp_valid))
                 state_nxt = S_RUN;
      default: state_nxt = S_BOOT;
    endcase
    if (redirect_valid)
      state_nxt = (redir_discard != '0) ? S_FLUSH : S_RUN;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_BOOT;
    else        state <= state_nxt;
  end

  // PC and in-flight bookkeeping; redirect overrides normal updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else if (redirect_valid) begin
      fetch_pc    <= redirect_pc & ~32'h3;
      outstanding <= redir_discard;
      discard     <= redir_discard;
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + 32'd4;
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      if (rsp_drop) discard <= discard - CW'(1);
    end
  end

  // Bookkeeping invariants: bounded counters, queues never overrun.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (outstanding <= DEPTH_C && discard <= DEPTH_C);
      assert (pcq_count == outstanding - discard);
      assert (!(pcq_full && req_fire));
      assert (!(fifo_full && rsp_keep && !if_pop));
    end
  end

endmodule
